cnt_seq_ctrl: RTL

CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

---
 rtl/cnt_seq_pkg.sv | 20 ++
 rtl/cnt_step_core.sv | 103 ++++++++++
 rtl/cnt_seq_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/cnt_seq_pkg.sv
// Shared encodings for the count sequencer: FSM states and run modes.
package cnt_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    // Modes 01/11 start at the top of the range counting down.
    function automatic logic mode_starts_down(input logic [1:0] m);
        return m[0];
    endfunction

endpackage

// File: rtl/cnt_step_core.sv
// Bounded up/down count register: loads a start position, steps per mode,
// and flags (o_term) when the pending step is a terminal/turnaround step.
module cnt_step_core
    import cnt_seq_pkg::*;
#(
    parameter int MAX = 15,
    parameter int MIN = 0,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         sys_rst,
    input  logic         i_load,
    input  logic [1:0]   i_load_mode,
    input  logic         i_step,
    input  logic [1:0]   i_mode,
    output logic [W-1:0] o_cnt,
    output logic         o_dir,
    output logic         o_tc,
    output logic         o_term
);

    localparam logic [W-1:0] HI = W'(MAX);
    localparam logic [W-1:0] LO = W'(MIN);

    logic [W-1:0] r_cnt;
    logic         r_dir;
    logic         r_tc;
    logic [W-1:0] w_nxt_cnt;
    logic         w_nxt_dir;
    logic         w_term;

    always_comb begin
        w_nxt_cnt = r_cnt;
        w_nxt_dir = r_dir;
        w_term    = 1'b0;
        case (i_mode)
            MODE_UP: begin
                if (r_cnt == HI) begin
                    w_nxt_cnt = LO;
                    w_term    = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + W'(1);
                end
            end
            MODE_DOWN: begin
                if (r_cnt == LO) begin
                    w_nxt_cnt = HI;
                    w_term    = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt - W'(1);
                end
            end
            MODE_BOUNCE: begin
                if (!r_dir && r_cnt == HI) begin
                    w_nxt_cnt = HI - W'(1);
                    w_nxt_dir = 1'b1;
                    w_term    = 1'b1;
                end else if (r_dir && r_cnt == LO) begin
                    w_nxt_cnt = LO + W'(1);
                    w_nxt_dir = 1'b0;
                    w_term    = 1'b1;
                end else if (r_dir) begin
                    w_nxt_cnt = r_cnt - W'(1);
                end else begin
                    w_nxt_cnt = r_cnt + W'(1);
                end
            end
            default: begin
                // One-shot: never step below MIN even if a tick sneaks in there.
                if (r_cnt == LO + W'(1)) begin
                    w_nxt_cnt = LO;
                    w_term    = 1'b1;
                end else if (r_cnt != LO) begin
                    w_nxt_cnt = r_cnt - W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_cnt <= LO;
            r_dir <= 1'b0;
            r_tc  <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (i_load) begin
                r_cnt <= mode_starts_down(i_load_mode) ? HI : LO;
                r_dir <= mode_starts_down(i_load_mode);
            end else if (i_step) begin
                r_cnt <= w_nxt_cnt;
                r_dir <= w_nxt_dir;
                r_tc  <= w_term;
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_dir  = r_dir;
    assign o_tc   = r_tc;
    assign o_term = w_term;

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Count sequencer top: IDLE/RUN/DONE FSM plus prescaler driving the
// bounded step core. stop always beats start and beats a same-cycle tick.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int MAX = 15,
    parameter int MIN = 0,
    parameter int DIV = 4,
    localparam int W  = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         sys_rst,
    input  logic         start,
    input  logic         stop,
    input  logic [1:0]   mode,
    output logic [W-1:0] cnt,
    output logic         dir,
    output logic         busy,
    output logic         tc,
    output logic         done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    if (MAX < MIN + 2 || DIV < 1) begin : g_param_check
        $error("cnt_seq_ctrl: requires MAX >= MIN+2 and DIV >= 1");
    end

    state_e        r_state;
    state_e        w_nxt_state;
    logic [1:0]    r_mode;
    logic [PW-1:0] r_presc;
    logic          w_run;
    logic          w_tick;
    logic          w_accept;
    logic          w_step;
    logic          w_term;

    assign w_run    = (r_state == ST_RUN);
    assign w_tick   = w_run && (r_presc == PW'(DIV - 1));
    assign w_accept = (r_state != ST_RUN) && start && !stop;
    assign w_step   = w_tick && !stop;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_UP;
            r_presc <= '0;
        end else begin
            r_state <= w_nxt_state;
            if (w_accept) r_mode <= mode;
            // Prescaler only runs in RUN; any exit or fresh start clears it.
            if (w_run && !stop) r_presc <= w_tick ? '0 : r_presc + PW'(1);
            else                r_presc <= '0;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nxt_state = ST_RUN;
            ST_RUN: begin
                if (stop)
                    w_nxt_state = ST_IDLE;
                else if (w_step && w_term && r_mode == MODE_ONESHOT)
                    w_nxt_state = ST_DONE;
            end
            ST_DONE: begin
                if (stop)          w_nxt_state = ST_IDLE;
                else if (w_accept) w_nxt_state = ST_RUN;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    cnt_step_core #(
        .MAX (MAX),
        .MIN (MIN),
        .W   (W)
    ) u_core (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .i_load      (w_accept),
        .i_load_mode (mode),
        .i_step      (w_step),
        .i_mode      (r_mode),
        .o_cnt       (cnt),
        .o_dir       (dir),
        .o_tc        (tc),
        .o_term      (w_term)
    );

    assign busy = w_run;
    assign done = (r_state == ST_DONE);

endmodule
